// File: rtl/nexus_keccak_pkg.sv
// Shared Keccak-f[1600] constants and helpers for the Nexus SK1024 Keccak-1024 stage.
// Lane index convention throughout: idx = x + 5*y, lane i at bits [64*i +: 64].
package nexus_keccak_pkg;

  localparam int unsigned LaneW     = 64;
  localparam int unsigned NumLanes  = 25;
  localparam int unsigned NumRounds = 24;
  localparam int unsigned NumPerms  = 3;
  localparam int unsigned RateLanes = 9;
  localparam int unsigned MsgLanes  = 16;
  localparam int unsigned StateW    = LaneW * NumLanes;
  // Block-2 lanes 9..15 wait alongside P1 (24 rounds x 2 register stages).
  localparam int unsigned DlyDepth  = 2 * NumRounds;
  localparam int unsigned DlyW      = LaneW * (MsgLanes - RateLanes);

  // Original Keccak pad10*1: 0x01 right after the 128-byte message, 0x80 in the last rate byte.
  localparam logic [LaneW-1:0] PadFirst = 64'h0000_0000_0000_0001;
  localparam logic [LaneW-1:0] PadLast  = 64'h8000_0000_0000_0000;

  typedef logic [LaneW-1:0] lane_t;
  typedef lane_t [NumLanes-1:0] state_t;

  function automatic int unsigned lane_idx(int unsigned x, int unsigned y);
    return x + 5 * y;
  endfunction

  function automatic lane_t rotl(lane_t v, int unsigned n);
    lane_t r;
    if (n == 0) r = v;
    else        r = (v << n) | (v >> (LaneW - n));
    return r;
  endfunction

  function automatic lane_t round_const(int unsigned r);
    lane_t rc;
    case (r)
      0:       rc = 64'h0000_0000_0000_0001;
      1:       rc = 64'h0000_0000_0000_8082;
      2:       rc = 64'h8000_0000_0000_808A;
      3:       rc = 64'h8000_0000_8000_8000;
      4:       rc = 64'h0000_0000_0000_808B;
      5:       rc = 64'h0000_0000_8000_0001;
      6:       rc = 64'h8000_0000_8000_8081;
      7:       rc = 64'h8000_0000_0000_8009;
      8:       rc = 64'h0000_0000_0000_008A;
      9:       rc = 64'h0000_0000_0000_0088;
      10:      rc = 64'h0000_0000_8000_8009;
      11:      rc = 64'h0000_0000_8000_000A;
      12:      rc = 64'h0000_0000_8000_808B;
      13:      rc = 64'h8000_0000_0000_008B;
      14:      rc = 64'h8000_0000_0000_8089;
      15:      rc = 64'h8000_0000_0000_8003;
      16:      rc = 64'h8000_0000_0000_8002;
      17:      rc = 64'h8000_0000_0000_0080;
      18:      rc = 64'h0000_0000_0000_800A;
      19:      rc = 64'h8000_0000_8000_000A;
      20:      rc = 64'h8000_0000_8000_8081;
      21:      rc = 64'h8000_0000_0000_8080;
      22:      rc = 64'h0000_0000_8000_0001;
      23:      rc = 64'h8000_0000_8000_8008;
      default: rc = '0;
    endcase
    return rc;
  endfunction

  // Rho rotation offsets indexed by x + 5*y.
  function automatic int unsigned rho_off(int unsigned idx);
    int unsigned n;
    case (idx)
      0:  n = 0;   1:  n = 1;   2:  n = 62;  3:  n = 28;  4:  n = 27;
      5:  n = 36;  6:  n = 44;  7:  n = 6;   8:  n = 55;  9:  n = 20;
      10: n = 3;   11: n = 10;  12: n = 43;  13: n = 25;  14: n = 39;
      15: n = 41;  16: n = 45;  17: n = 15;  18: n = 21;  19: n = 8;
      20: n = 18;  21: n = 2;   22: n = 61;  23: n = 56;  24: n = 14;
      default: n = 0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/keccak_round.sv
// One Keccak-f[1600] round split over two register stages:
// stage A holds theta, stage B holds rho/pi/chi/iota.
module keccak_round
  import nexus_keccak_pkg::*;
#(
  parameter int unsigned Round = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [StateW-1:0] state_i,
  output logic [StateW-1:0] state_o
);

  localparam lane_t Rc = round_const(Round);

  state_t      s_in;
  lane_t [4:0] col;
  lane_t [4:0] dcol;
  state_t      theta_d, theta_q;
  state_t      perm;
  state_t      chi_d, chi_q;

  assign s_in = state_i;

  always_comb begin
    col     = '0;
    dcol    = '0;
    theta_d = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      col[x] = s_in[x] ^ s_in[x + 5] ^ s_in[x + 10] ^ s_in[x + 15] ^ s_in[x + 20];
    end
    for (int unsigned x = 0; x < 5; x++) begin
      dcol[x] = col[(x + 4) % 5] ^ rotl(col[(x + 1) % 5], 1);
    end
    for (int unsigned i = 0; i < NumLanes; i++) begin
      theta_d[i] = s_in[i] ^ dcol[i % 5];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      theta_q <= '0;
    end else begin
      theta_q <= theta_d;
    end
  end

  // Pi moves lane (x,y) to (y, 2x+3y); rho rotation is applied on the way.
  always_comb begin
    perm  = '0;
    chi_d = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      for (int unsigned y = 0; y < 5; y++) begin
        perm[lane_idx(y, (2 * x + 3 * y) % 5)] =
          rotl(theta_q[lane_idx(x, y)], rho_off(lane_idx(x, y)));
      end
    end
    for (int unsigned x = 0; x < 5; x++) begin
      for (int unsigned y = 0; y < 5; y++) begin
        chi_d[lane_idx(x, y)] = perm[lane_idx(x, y)] ^
          (~perm[lane_idx((x + 1) % 5, y)] & perm[lane_idx((x + 2) % 5, y)]);
      end
    end
    chi_d[0] = chi_d[0] ^ Rc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chi_q <= '0;
    end else begin
      chi_q <= chi_d;
    end
  end

  assign state_o = chi_q;

endmodule

// File: rtl/nexus_keccak1024_core.sv
// Fully pipelined Keccak-1024 (rate 576) over a 1024-bit message: P1 absorb, P2 absorb,
// P3 squeeze; returns digest qword 15 (P3 lane 6) after 144 cycles, one message per clock.
module nexus_keccak1024_core
  import nexus_keccak_pkg::*;
(
  input  logic          clk,
  input  logic          nHashRst,
  input  logic [1023:0] In,
  output logic [63:0]   Out
);

  localparam int unsigned NumStages = NumPerms * NumRounds;

  state_t            chain [NumStages + 1];
  state_t            absorb;
  logic   [DlyW-1:0] dly_q [DlyDepth];

  // P1 starts from block 1 in lanes 0..8 with an all-zero capacity.
  always_comb begin
    chain[0]               = '0;
    chain[0][RateLanes-1:0] = In[RateLanes*LaneW-1:0];
  end

  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      for (int i = 0; i < DlyDepth; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= In[MsgLanes*LaneW-1:RateLanes*LaneW];
      for (int i = 1; i < DlyDepth; i++) begin
        dly_q[i] <= dly_q[i - 1];
      end
    end
  end

  // Block 2 with padding, aligned to the P1 result of the same message.
  always_comb begin
    absorb    = '0;
    absorb[6:0] = dly_q[DlyDepth - 1];
    absorb[7] = PadFirst;
    absorb[8] = PadLast;
  end

  for (genvar g = 0; g < NumStages; g++) begin : g_round
    state_t rin;
    if (g == NumRounds) begin : g_absorb
      assign rin = chain[g] ^ absorb;
    end else begin : g_pass
      assign rin = chain[g];
    end

    keccak_round #(
      .Round(g % NumRounds)
    ) u_round (
      .clk_i  (clk),
      .rst_ni (nHashRst),
      .state_i(rin),
      .state_o(chain[g + 1])
    );
  end

  assign Out = chain[NumStages][6];

endmodule

// File: tb/tb_nexus_keccak1024_core.sv
// Scoreboard bench for nexus_keccak1024_core using an independent compact Keccak-f model.
module tb_nexus_keccak1024_core;

  logic          clk = 1'b0;
  logic          nHashRst;
  logic [1023:0] In;
  logic [63:0]   Out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0]  exp_q [$];
  logic         tb_valid;
  logic [143:0] vld_sr;

  always #5 clk = ~clk;

  nexus_keccak1024_core dut (
    .clk     (clk),
    .nHashRst(nHashRst),
    .In      (In),
    .Out     (Out)
  );

  function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (64 - n));
  endfunction

  // Compact Keccak-f[1600]: in-place rho/pi walk and LFSR-generated round constants.
  function automatic logic [1599:0] kf(input logic [1599:0] s_in);
    logic [63:0]   a [25];
    logic [63:0]   c [5];
    logic [63:0]   bc [5];
    logic [63:0]   d, cur, tmp, rc;
    logic [7:0]    r;
    logic [1599:0] s_out;
    int            x, y, nx, ny;
    for (int i = 0; i < 25; i++) a[i] = s_in[64*i +: 64];
    r = 8'd1;
    for (int rnd = 0; rnd < 24; rnd++) begin
      for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i+5] ^ a[i+10] ^ a[i+15] ^ a[i+20];
      for (int i = 0; i < 5; i++) begin
        d = c[(i + 4) % 5] ^ rotl64(c[(i + 1) % 5], 1);
        for (int j = 0; j < 5; j++) a[i + 5*j] = a[i + 5*j] ^ d;
      end
      x = 1; y = 0; cur = a[1];
      for (int t = 0; t < 24; t++) begin
        nx = y;
        ny = (2*x + 3*y) % 5;
        tmp = a[nx + 5*ny];
        a[nx + 5*ny] = rotl64(cur, ((t + 1) * (t + 2) / 2) % 64);
        cur = tmp;
        x = nx;
        y = ny;
      end
      for (int j = 0; j < 5; j++) begin
        for (int i = 0; i < 5; i++) bc[i] = a[i + 5*j];
        for (int i = 0; i < 5; i++) a[i + 5*j] = bc[i] ^ (~bc[(i + 1) % 5] & bc[(i + 2) % 5]);
      end
      rc = '0;
      for (int j = 0; j < 7; j++) begin
        r = {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
        if (r[1]) rc[(1 << j) - 1] = 1'b1;
      end
      a[0] = a[0] ^ rc;
    end
    for (int i = 0; i < 25; i++) s_out[64*i +: 64] = a[i];
    return s_out;
  endfunction

  function automatic logic [63:0] model_out(input logic [1023:0] m);
    logic [1599:0] s;
    s = '0;
    s[575:0] = m[575:0];
    s = kf(s);
    s[575:0] = s[575:0] ^ {64'h8000000000000000, 64'h0000000000000001, m[1023:576]};
    s = kf(s);
    s = kf(s);
    return s[6*64 +: 64];
  endfunction

  function automatic logic [1023:0] rand_msg();
    logic [1023:0] m;
    for (int i = 0; i < 32; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  task automatic send(input logic [1023:0] m);
    In = m;
    tb_valid = 1'b1;
    exp_q.push_back(model_out(m));
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (Out !== 64'h0) begin
      n_errors++;
      $display("FAIL %s: Out=%h required 0000000000000000", name, Out);
    end
  endtask

  // Tracks which pipeline slots carry a scoreboarded message.
  always @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) vld_sr <= '0;
    else           vld_sr <= {vld_sr[142:0], tb_valid};
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (nHashRst === 1'b1 && vld_sr[143]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL out_unexpected: Out=%h with no expected entry", Out);
      end else begin
        e = exp_q.pop_front();
        if (Out !== e) begin
          n_errors++;
          $display("FAIL out_q15: Out=%h required %h", Out, e);
        end
      end
    end
  end

  task automatic drain(input string name);
    int budget;
    budget = 0;
    tb_valid = 1'b0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d results outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    logic [1023:0] base, m;
    logic [1599:0] zs;
    logic [63:0]   kat;

    nHashRst = 1'b0;
    In       = '0;
    tb_valid = 1'b0;

    // Model sanity: Keccak-f[1600] of the zero state, lane 0.
    zs  = '0;
    zs  = kf(zs);
    kat = zs[63:0];
    n_checks++;
    if (kat !== 64'hF1258F7940E1DDE7) begin
      n_errors++;
      $display("FAIL model_kat: lane0=%h required f1258f7940e1dde7", kat);
    end

    repeat (3) begin
      @(negedge clk);
      check_zero("reset_init");
    end
    nHashRst = 1'b1;
    @(negedge clk);

    // Zero message stream, then a single-cycle lane0=1 pulse inside zeros.
    repeat (150) send('0);
    m = '0;
    m[0] = 1'b1;
    send(m);
    repeat (150) send('0);

    // Block-2 lane mapping and pad placement.
    base = rand_msg();
    send(base);
    m = base;
    m[1023] = ~m[1023];
    send(m);
    m = base;
    m[576] = ~m[576];
    send(m);
    m = '0;
    m[1023] = 1'b1;
    send(m);
    m = '0;
    m[576] = 1'b1;
    send(m);

    // Back-to-back throughput.
    repeat (300) send(rand_msg());
    drain("drain_main");

    // Mid-stream asynchronous reset.
    repeat (60) send(rand_msg());
    @(posedge clk);
    #2;
    nHashRst = 1'b0;
    tb_valid = 1'b0;
    exp_q.delete();
    #1;
    check_zero("reset_async");
    repeat (5) begin
      @(negedge clk);
      In = rand_msg();
      check_zero("reset_hold");
    end
    nHashRst = 1'b1;

    // Recovery after reset.
    repeat (160) send(rand_msg());
    drain("drain_post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
